mssb_rx_fifo: RTL
=================

Name: mssb_rx_fifo

Overview:
- Receive-side buffer directly downstream of the cmn_uart receiver on the MSSB link.
- Consumes the UART DATA_STREAM_OUT byte stream using its STB/ACK handshake and stores the bytes in a synchronous FIFO.
- Software drains the FIFO over the OPB register bus, which replaces the pattern-checker with real payload capture.
- Reports FIFO level, full/empty and a saturating overrun count.

Parameters:
- FIFO_DEPTH, 256, number of byte entries; must be a power of two.
- ADDR_W, 8, log2(FIFO_DEPTH); level width is ADDR_W+1.

Ports:
- OPB_CLK  in  1  100 MHz clock.
- OPB_RST  in  1  reset, asynchronous, active-high.
- OPB_ADDR  in  32  register address; only [3:0] is decoded.
- OPB_DI  in  32  write data.
- RXF_RE  in  1  read strobe; one access per asserted cycle.
- RXF_WE  in  1  write strobe; one access per asserted cycle.
- OPB_DO  out  32  registered read data.
- RX_DATA  in  8  byte from the UART receiver; valid while RX_STB=1.
- RX_STB  in  1  receiver strobe.
- RX_ACK  out  1  acknowledge pulse to the receiver.
- RXF_NOT_EMPTY  out  1  level != 0; intended as an interrupt source.

Behaviour:
- Reset values: OPB_DO=0, RX_ACK=0, RXF_NOT_EMPTY=0, pointers=0, level=0, overrun_cnt=0, overrun_flag=0, handshake state RX_WAIT.
- Handshake FSM:
  - RX_WAIT: if RX_STB=1, take RX_DATA, drive RX_ACK=1 for exactly one cycle (registered), then go to RX_HOLD.
  - RX_HOLD: RX_ACK=0; return to RX_WAIT only after RX_STB=0 is seen.
  - Each STB assertion is taken exactly once, even if STB stays high for many cycles.
- Push: the taken byte is written at wr_ptr when it is accepted.
  - Accepted if level<FIFO_DEPTH, or if a pop occurs in the same cycle.
  - If not accepted: byte dropped, RX_ACK is still issued (the link never stalls), overrun_cnt+1 saturating at 20'hFFFFF, overrun_flag=1.
- Pop: RXF_RE=1 with OPB_ADDR[3:0]=4'h0 while level>0.
  - OPB_DO next cycle = {23'b0, 1'b1, mem[rd_ptr]}; rd_ptr+1.
  - On empty: OPB_DO={32'h0}, no pointer change.
- Simultaneous push and pop: both occur and level is unchanged.
- Pointers wrap modulo FIFO_DEPTH.
- Level is a counter in 0..FIFO_DEPTH; full = (level==FIFO_DEPTH), empty = (level==0).
- Register map (offset in OPB_ADDR[3:0]):
  - 4'h0 DATA (read, pops): {[8]:valid, [7:0]:byte}.
  - 4'h1 STATUS (read): {[31]:overrun_flag, [17]:full, [16]:empty, [ADDR_W:0]:level}.
  - 4'h2 OVERRUN (read): {[19:0]:overrun_cnt}.
  - 4'h3 CONTROL (write): [0] flush, [1] clear overrun; both self-acting, reading returns 0.
- Reads are registered with 1-cycle latency. OPB_DO=0 on any cycle without a decoded read. Unmapped offsets read as 0 and ignore writes.
- Flush: pointers and level go to 0 on the next edge.
  - Flush beats a push or pop in the same cycle; that byte is discarded and is NOT counted as overrun.
  - Handshake FSM state is unaffected.
- Clear overrun: overrun_cnt=0, overrun_flag=0. An overrun in the same cycle loses to the clear.
- STATUS sampled in the same cycle as a push or pop returns the pre-update level.
- RXF_NOT_EMPTY is registered and derived from the updated level (changes in the cycle after the push or pop).
- Reset asserted mid-transfer returns everything to reset values immediately; FIFO contents are don't-care.

Test Plan:
- Reset, then read 4'h1 -> OPB_DO=32'h0001_0000 (empty=1, level=0); read 4'h0 -> 32'h0, RXF_NOT_EMPTY=0.
- Send bytes 0x00..0x09, STB held 5 cycles each -> exactly 10 RX_ACK pulses, level=10. Ten DATA reads return 0x100..0x109 in order; level returns to 0.
- Send 260 bytes with no reads (DEPTH=256) -> STATUS full=1, level=256, overrun_flag=1, OVERRUN=4. Drained bytes are 0x00..0xFF; the last 4 were dropped.
- With level=256, push and DATA pop in the same cycle -> byte accepted, level stays 256, overrun_cnt unchanged.
- Write CONTROL=0x1 in the same cycle as an accepted push, with level=5 -> level=0, overrun_cnt unchanged. Write CONTROL=0x2 -> OVERRUN=0, flag=0.
- Assert OPB_RST while RX_STB=1 in RX_HOLD with level=7 -> RX_ACK=0, level=0. After release, STB still high is taken once as a new byte.

Source files
------------

// File: rtl/mssb_rx_fifo.sv
`default_nettype none
// ============================================================================
//  Module   : mssb_rx_fifo
//  Brief    : MSSB receive buffer. Takes bytes from the UART receiver with an
//             STB/ACK handshake, stores them in a synchronous FIFO and lets
//             software drain them, check the level and track overruns over
//             the OPB register bus.
//  Revision : 1.0  initial release
// ============================================================================
module mssb_rx_fifo #(
    parameter int FIFO_DEPTH = 256,
    parameter int ADDR_W     = 8
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic [31:0] OPB_ADDR,
    input  logic [31:0] OPB_DI,
    input  logic        RXF_RE,
    input  logic        RXF_WE,
    output logic [31:0] OPB_DO,
    input  logic [7:0]  RX_DATA,
    input  logic        RX_STB,
    output logic        RX_ACK,
    output logic        RXF_NOT_EMPTY
);

    localparam logic [0:0]      c_RX_WAIT  = 1'b0;
    localparam logic [0:0]      c_RX_HOLD  = 1'b1;
    localparam logic [ADDR_W:0] c_DEPTH    = (ADDR_W + 1)'(FIFO_DEPTH);
    localparam logic [19:0]     c_OVR_MAX  = 20'hFFFFF;

    logic [0:0]        r_state;
    logic [0:0]        w_state_nxt;
    logic              w_take;
    logic              r_rx_ack;

    logic [7:0]        r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0] r_wr_ptr;
    logic [ADDR_W-1:0] r_rd_ptr;
    logic [ADDR_W:0]   r_level;
    logic [ADDR_W:0]   w_level_nxt;
    logic [19:0]       r_ovr_cnt;
    logic              r_ovr_flag;
    logic              r_not_empty;
    logic [31:0]       r_do;
    logic [31:0]       w_rd_data;

    logic [3:0]        w_sel;
    logic              w_flush;
    logic              w_clr;
    logic              w_full;
    logic              w_empty;
    logic              w_pop;
    logic              w_push;
    logic              w_overrun;
    logic              w_unused_bits;

    assign w_unused_bits = ^{OPB_ADDR[31:4], OPB_DI[31:2]};

    // Handshake: take one byte per STB assertion, then wait for STB to drop.
    always_comb begin
        w_state_nxt = r_state;
        w_take      = 1'b0;
        case (r_state)
            c_RX_WAIT: begin
                if (RX_STB) begin
                    w_take      = 1'b1;
                    w_state_nxt = c_RX_HOLD;
                end
            end
            c_RX_HOLD: begin
                if (!RX_STB) begin
                    w_state_nxt = c_RX_WAIT;
                end
            end
            default: w_state_nxt = c_RX_WAIT;
        endcase
    end

    // Handshake state and the one-cycle registered acknowledge.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_state  <= c_RX_WAIT;
            r_rx_ack <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_rx_ack <= w_take;
        end
    end

    // Bus decode; flush overrides any push or pop issued in the same cycle.
    assign w_sel     = OPB_ADDR[3:0];
    assign w_flush   = RXF_WE && (w_sel == 4'h3) && OPB_DI[0];
    assign w_clr     = RXF_WE && (w_sel == 4'h3) && OPB_DI[1];
    assign w_full    = (r_level == c_DEPTH);
    assign w_empty   = (r_level == '0);
    assign w_pop     = RXF_RE && (w_sel == 4'h0) && !w_empty && !w_flush;
    assign w_push    = w_take && !w_flush && (!w_full || w_pop);
    assign w_overrun = w_take && !w_flush && w_full && !w_pop;

    // Next fill level; a simultaneous push and pop leaves it unchanged.
    always_comb begin
        w_level_nxt = r_level;
        if (w_flush) begin
            w_level_nxt = '0;
        end else if (w_push && !w_pop) begin
            w_level_nxt = r_level + 1'b1;
        end else if (w_pop && !w_push) begin
            w_level_nxt = r_level - 1'b1;
        end
    end

    // Read mux; everything not selected by a decoded read returns zero.
    always_comb begin
        w_rd_data = '0;
        if (RXF_RE) begin
            case (w_sel)
                4'h0: begin
                    if (w_pop) begin
                        w_rd_data = {23'b0, 1'b1, r_mem[r_rd_ptr]};
                    end
                end
                4'h1: begin
                    w_rd_data[ADDR_W:0] = r_level;
                    w_rd_data[16]       = w_empty;
                    w_rd_data[17]       = w_full;
                    w_rd_data[31]       = r_ovr_flag;
                end
                4'h2:    w_rd_data = {12'b0, r_ovr_cnt};
                default: w_rd_data = '0;
            endcase
        end
    end

    // Byte storage; contents need no reset.
    always_ff @(posedge OPB_CLK) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= RX_DATA;
        end
    end

    // Pointers, level, not-empty flag and read data register.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_wr_ptr    <= '0;
            r_rd_ptr    <= '0;
            r_level     <= '0;
            r_not_empty <= 1'b0;
            r_do        <= '0;
        end else begin
            if (w_flush) begin
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
                if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_level     <= w_level_nxt;
            r_not_empty <= (w_level_nxt != '0);
            r_do        <= w_rd_data;
        end
    end

    // Saturating overrun counter; a clear wins over a same-cycle overrun.
    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            r_ovr_cnt  <= '0;
            r_ovr_flag <= 1'b0;
        end else if (w_clr) begin
            r_ovr_cnt  <= '0;
            r_ovr_flag <= 1'b0;
        end else if (w_overrun) begin
            r_ovr_flag <= 1'b1;
            if (r_ovr_cnt != c_OVR_MAX) begin
                r_ovr_cnt <= r_ovr_cnt + 1'b1;
            end
        end
    end

    assign OPB_DO        = r_do;
    assign RX_ACK        = r_rx_ack;
    assign RXF_NOT_EMPTY = r_not_empty;

endmodule
`default_nettype wire
